uart_in_responder: RTL and testbench

UART_IN_RESPONDER -- requirements
Module: uart_in_responder

---
 rtl/uart_in_responder.sv | 73 +++++++
 tb/tb_uart_in_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_in_responder.sv
// Host-fed character FIFO that answers SoC-side UART read requests with zero latency,
// returning EMPTY_CH when nothing is deliverable and enforcing an idle gap after each delivery.
module uart_in_responder #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [7:0]  EMPTY_CH = 8'hff,
  parameter int unsigned GAP      = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [7:0]               push_ch,
  output logic                     push_ready,
  input  logic                     uart_in_valid,
  output logic [7:0]               uart_in_ch,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              delivered_cnt,
  output logic [31:0]              empty_read_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [15:0]   GAP_LOAD   = 16'(GAP);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   gap_cnt;
  logic          deliverable;
  logic          push_fire;
  logic          pop_fire;

  // Full/empty decisions come from registered state only, so a pop never frees a slot
  // for a push in the same cycle and a fresh push is never bypassed to the reader.
  assign deliverable = (level != '0) && (gap_cnt == '0);
  assign push_ready  = (level != FULL_LEVEL);
  assign push_fire   = push_valid && push_ready && reset;
  assign pop_fire    = uart_in_valid && deliverable;
  assign uart_in_ch  = deliverable ? mem[rd_ptr] : EMPTY_CH;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      gap_cnt        <= '0;
      delivered_cnt  <= '0;
      empty_read_cnt <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;

      case ({push_fire, pop_fire})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (pop_fire)              gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0)    gap_cnt <= gap_cnt - 1'b1;

      if (pop_fire)                       delivered_cnt  <= delivered_cnt + 32'd1;
      if (uart_in_valid && !deliverable)  empty_read_cnt <= empty_read_cnt + 32'd1;
    end
  end

  // NOTE: storage has no reset; pointers and level decide what is valid, so stale bytes are unreachable.
  always_ff @(posedge clock) begin
    if (push_fire) mem[wr_ptr] <= push_ch;
  end

endmodule

// File: tb/tb_uart_in_responder.sv
// Self-checking bench: two responders (GAP=0 and GAP=4) share stimulus and are compared every
// cycle against a queue-based model; directed scenarios pin the model with literal expectations.
module tb_uart_in_responder;

  logic        clock;
  logic        reset;
  logic        push_valid;
  logic [7:0]  push_ch;
  logic        uart_in_valid;

  logic        pr  [2];
  logic [7:0]  ch  [2];
  logic [4:0]  lvl [2];
  logic [31:0] dc  [2];
  logic [31:0] ec  [2];

  int checks   = 0;
  int failures = 0;

  uart_in_responder #(.DEPTH(16), .EMPTY_CH(8'hff), .GAP(0)) u0 (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_ch(push_ch), .push_ready(pr[0]),
    .uart_in_valid(uart_in_valid), .uart_in_ch(ch[0]),
    .level(lvl[0]), .delivered_cnt(dc[0]), .empty_read_cnt(ec[0])
  );

  uart_in_responder #(.DEPTH(16), .EMPTY_CH(8'hff), .GAP(4)) u1 (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_ch(push_ch), .push_ready(pr[1]),
    .uart_in_valid(uart_in_valid), .uart_in_ch(ch[1]),
    .level(lvl[1]), .delivered_cnt(dc[1]), .empty_read_cnt(ec[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a byte queue, a gap countdown and two counters per instance.
  logic [7:0]  mq  [2][$];
  int          gm  [2];
  logic [31:0] dm  [2];
  logic [31:0] em  [2];
  int          gp  [2] = '{0, 4};
  bit          armed = 0;

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      bit   deliv;
      logic [7:0] exp_ch;
      deliv  = (mq[i].size() != 0) && (gm[i] == 0);
      exp_ch = deliv ? mq[i][0] : 8'hff;
      if (armed) begin
        check($sformatf("model_level%0d", i), 32'(lvl[i]), 32'(mq[i].size()));
        check($sformatf("model_ready%0d", i), 32'(pr[i]), 32'(mq[i].size() != 16));
        check($sformatf("model_ch%0d", i), 32'(ch[i]), 32'(exp_ch));
        check($sformatf("model_dcnt%0d", i), dc[i], dm[i]);
        check($sformatf("model_ecnt%0d", i), ec[i], em[i]);
      end
      // Advance the model to the state after the coming rising edge.
      if (!reset) begin
        mq[i].delete();
        gm[i] = 0;
        dm[i] = 0;
        em[i] = 0;
      end else begin
        bit pushing;
        pushing = push_valid && (mq[i].size() != 16);
        if (uart_in_valid && !deliv) em[i] = em[i] + 1;
        if (uart_in_valid && deliv) begin
          void'(mq[i].pop_front());
          dm[i] = dm[i] + 1;
          gm[i] = gp[i];
        end else if (gm[i] > 0) begin
          gm[i] = gm[i] - 1;
        end
        if (pushing) mq[i].push_back(push_ch);
      end
    end
    if (!reset) armed = 1;
  end

  task automatic drive(input logic r, input logic pv, input logic [7:0] pc, input logic rv);
    @(posedge clock);
    #1;
    reset         = r;
    push_valid    = pv;
    push_ch       = pc;
    uart_in_valid = rv;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset         = 1'b0;
    push_valid    = 1'b0;
    push_ch       = 8'h00;
    uart_in_valid = 1'b0;

    // Empty reads straight after reset.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      @(negedge clock);
      if (k == 0) begin
        check("rst_level", 32'(lvl[0]), 32'd0);
        check("rst_ready", 32'(pr[0]), 32'd1);
        check("rst_dcnt", dc[0], 32'd0);
      end
      check("empty_ch0", 32'(ch[0]), 32'hff);
      check("empty_ch1", 32'(ch[1]), 32'hff);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    check("empty_ecnt", ec[0], 32'd3);
    check("empty_dcnt", dc[0], 32'd0);

    // Order with GAP=0.
    do_reset();
    drive(1'b1, 1'b1, 8'h61, 1'b0);
    drive(1'b1, 1'b1, 8'h62, 1'b0);
    drive(1'b1, 1'b1, 8'h63, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      @(negedge clock);
      check("order_level", 32'(lvl[0]), 32'(3 - k));
      check("order_ch", 32'(ch[0]), 32'(8'h61 + k));
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    check("order_level_end", 32'(lvl[0]), 32'd0);
    check("order_dcnt", dc[0], 32'd3);

    // Full FIFO: 17th push dropped, pop while full does not admit a push.
    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 8'(i + 1), 1'b0);
    drive(1'b1, 1'b1, 8'h11, 1'b0);
    @(negedge clock);
    check("full_level", 32'(lvl[0]), 32'd16);
    check("full_ready", 32'(pr[0]), 32'd0);
    drive(1'b1, 1'b1, 8'h99, 1'b1);
    @(negedge clock);
    check("full_popch", 32'(ch[0]), 32'h01);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    check("full_level15", 32'(lvl[0]), 32'd15);
    check("full_ready15", 32'(pr[0]), 32'd1);
    for (int k = 2; k <= 16; k++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      @(negedge clock);
      check("full_drain", 32'(ch[0]), 32'(k));
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    @(negedge clock);
    check("full_drained", 32'(ch[0]), 32'hff);

    // Gap of 4 on u1.
    do_reset();
    drive(1'b1, 1'b1, 8'h10, 1'b0);
    drive(1'b1, 1'b1, 8'h20, 1'b0);
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      @(negedge clock);
      check("gap_ch", 32'(ch[1]), (c == 0) ? 32'h10 : (c == 5) ? 32'h20 : 32'hff);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    check("gap_ecnt", ec[1], 32'd4);
    check("gap_dcnt", dc[1], 32'd2);

    // No bypass from an empty FIFO.
    do_reset();
    drive(1'b1, 1'b1, 8'h41, 1'b1);
    @(negedge clock);
    check("nobypass_same", 32'(ch[0]), 32'hff);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    @(negedge clock);
    check("nobypass_next", 32'(ch[0]), 32'h41);

    // Mid-operation reset on u1 with level=5 and a pending gap of 3.
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 8'(8'h30 + i), 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 8'h77, 1'b1);
    @(negedge clock);
    check("midrst_pre_level", 32'(lvl[1]), 32'd5);
    check("midrst_pre_dcnt", dc[1], 32'd1);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    check("midrst_level", 32'(lvl[1]), 32'd0);
    check("midrst_ch", 32'(ch[1]), 32'hff);
    check("midrst_ready", 32'(pr[1]), 32'd1);
    check("midrst_dcnt", dc[1], 32'd0);
    check("midrst_ecnt", ec[1], 32'd0);
    drive(1'b1, 1'b1, 8'h55, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    @(negedge clock);
    check("midrst_fresh", 32'(ch[1]), 32'h55);

    // Randomized traffic alternating fill-heavy and drain-heavy phases.
    for (int n = 0; n < 4000; n++) begin
      bit heavy;
      logic r, pv, rv;
      heavy = ((n / 500) % 2) == 0;
      r  = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      pv = ($urandom_range(0, 99) < (heavy ? 85 : 30));
      rv = ($urandom_range(0, 99) < (heavy ? 40 : 80));
      drive(r, pv, 8'($urandom), rv);
    end

    drive(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
